// File: rtl/l2_scrub_pkg.sv
// Shared types and default parameters for the L2 background ECC scrubber.
package l2_scrub_pkg;

  localparam int unsigned DefAddrWidth     = 17;
  localparam int unsigned DefDataWidth     = 64;
  localparam int unsigned DefNumWords      = 2**17;
  localparam int unsigned DefIntervalWidth = 16;
  localparam int unsigned DefCntWidth      = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRead,
    StResp,
    StWrite,
    StNext
  } scrub_state_e;

endpackage

// File: rtl/l2_scrub_sat_cnt.sv
// Saturating up-counter with a clear that wins over a same-cycle increment.
module l2_scrub_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/l2_scrub_ctrl.sv
// Background ECC scrubber: walks L2 words, writes back corrected data and
// logs uncorrectable words, always yielding the port to functional traffic.
module l2_scrub_ctrl
  import l2_scrub_pkg::*;
#(
  parameter int unsigned AddrWidth     = DefAddrWidth,
  parameter int unsigned DataWidth     = DefDataWidth,
  parameter int unsigned NumWords      = DefNumWords,
  parameter int unsigned IntervalWidth = DefIntervalWidth,
  parameter int unsigned CntWidth      = DefCntWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [IntervalWidth-1:0] interval_i,
  input  logic                     clr_cnt_i,
  input  logic                     bus_busy_i,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic                     mem_we_o,
  output logic [AddrWidth-1:0]     mem_addr_o,
  output logic [DataWidth-1:0]     mem_wdata_o,
  input  logic                     mem_rvalid_i,
  input  logic [DataWidth-1:0]     mem_rdata_i,
  input  logic                     mem_err_single_i,
  input  logic                     mem_err_multi_i,
  output logic [CntWidth-1:0]      corr_cnt_o,
  output logic [CntWidth-1:0]      uncorr_cnt_o,
  output logic [AddrWidth-1:0]     uncorr_addr_o,
  output logic                     sweep_done_o,
  output logic                     busy_o
);

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  scrub_state_e             state_q, state_d;
  logic [AddrWidth-1:0]     addr_q, addr_d;
  logic [IntervalWidth-1:0] intv_q, intv_d;
  logic [DataWidth-1:0]     wdata_q, wdata_d;
  logic [AddrWidth-1:0]     uaddr_q, uaddr_d;
  logic                     sweep_done_q, sweep_done_d;
  logic                     we_q;
  logic                     busy_q;
  logic                     req_state;
  logic                     accept;
  logic                     corr_inc;
  logic                     uncorr_inc;

  // Request is the only combinational output: functional traffic masks it instantly.
  assign req_state = (state_q == StRead) || (state_q == StWrite);
  assign mem_req_o = req_state & ~bus_busy_i;
  assign accept    = mem_req_o & mem_gnt_i;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    intv_d       = intv_q;
    wdata_d      = wdata_q;
    uaddr_d      = uaddr_q;
    sweep_done_d = 1'b0;
    corr_inc     = 1'b0;
    uncorr_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d = StWait;
          intv_d  = interval_i;
        end
      end
      StWait: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (intv_q == '0) begin
          state_d = StRead;
        end else begin
          intv_d = intv_q - IntervalWidth'(1);
        end
      end
      StRead: begin
        if (accept) begin
          state_d = StResp;
        end
      end
      StResp: begin
        // Uncorrectable wins: rewriting data the ECC could not fix would bless it.
        if (mem_rvalid_i) begin
          if (mem_err_multi_i) begin
            uncorr_inc = 1'b1;
            uaddr_d    = addr_q;
            state_d    = StNext;
          end else if (mem_err_single_i) begin
            corr_inc = 1'b1;
            wdata_d  = mem_rdata_i;
            state_d  = StWrite;
          end else begin
            state_d = StNext;
          end
        end
      end
      StWrite: begin
        if (accept) begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (addr_q == LastAddr) begin
          addr_d       = '0;
          sweep_done_d = 1'b1;
        end else begin
          addr_d = addr_q + AddrWidth'(1);
        end
        if (enable_i) begin
          state_d = StWait;
          intv_d  = interval_i;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      intv_q       <= '0;
      wdata_q      <= '0;
      uaddr_q      <= '0;
      sweep_done_q <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      intv_q       <= intv_d;
      wdata_q      <= wdata_d;
      uaddr_q      <= uaddr_d;
      sweep_done_q <= sweep_done_d;
      we_q         <= (state_d == StWrite);
      busy_q       <= (state_d != StIdle);
    end
  end

  l2_scrub_sat_cnt #(
    .Width (CntWidth)
  ) u_corr_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_cnt_i),
    .inc_i (corr_inc),
    .cnt_o (corr_cnt_o)
  );

  l2_scrub_sat_cnt #(
    .Width (CntWidth)
  ) u_uncorr_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_cnt_i),
    .inc_i (uncorr_inc),
    .cnt_o (uncorr_cnt_o)
  );

  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign uncorr_addr_o = uaddr_q;
  assign sweep_done_o  = sweep_done_q;
  assign busy_o        = busy_q;

  // The interconnect may sample address/direction on any cycle of a pending request.
  a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (req_state && !accept) |=> ($stable(mem_addr_o) && $stable(mem_we_o)));

  a_we_decode : assert property (@(posedge clk_i) disable iff (rst_i)
    req_state |-> (mem_we_o == (state_q == StWrite)));

endmodule

// File: tb/tb_l2_scrub_ctrl.sv
// Directed and randomized bench for l2_scrub_ctrl against a word-level scrub model.
module tb_l2_scrub_ctrl;

  localparam int unsigned AW     = 3;
  localparam int unsigned DW     = 64;
  localparam int unsigned NW     = 8;
  localparam int unsigned IW     = 4;
  localparam int unsigned CW     = 4;
  localparam int          CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [IW-1:0] interval = '0;
  logic          clr_cnt = 1'b0;
  logic          bus_busy = 1'b0;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          err_single = 1'b0;
  logic          err_multi = 1'b0;
  logic          mem_req, mem_we, sweep_done, busy;
  logic [AW-1:0] mem_addr, uncorr_addr;
  logic [DW-1:0] mem_wdata;
  logic [CW-1:0] corr_cnt, uncorr_cnt;

  l2_scrub_ctrl #(
    .AddrWidth     (AW),
    .DataWidth     (DW),
    .NumWords      (NW),
    .IntervalWidth (IW),
    .CntWidth      (CW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .enable_i         (enable),
    .interval_i       (interval),
    .clr_cnt_i        (clr_cnt),
    .bus_busy_i       (bus_busy),
    .mem_req_o        (mem_req),
    .mem_gnt_i        (mem_gnt),
    .mem_we_o         (mem_we),
    .mem_addr_o       (mem_addr),
    .mem_wdata_o      (mem_wdata),
    .mem_rvalid_i     (mem_rvalid),
    .mem_rdata_i      (mem_rdata),
    .mem_err_single_i (err_single),
    .mem_err_multi_i  (err_multi),
    .corr_cnt_o       (corr_cnt),
    .uncorr_cnt_o     (uncorr_cnt),
    .uncorr_addr_o    (uncorr_addr),
    .sweep_done_o     (sweep_done),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Word-level model of what the scrubber must have done so far.
  int            exp_addr = 0, exp_corr = 0, exp_uncorr = 0, exp_uaddr = 0;
  int            exp_sweeps = 0, seen_sweeps = 0;
  bit            exp_wr_pend = 0;
  logic [DW-1:0] exp_wdata = '0;
  bit            chk_cnt = 0;

  // Memory responder state and stimulus knobs.
  bit            rsp_pend = 0, rsp_stale = 0, rsp_single = 0, rsp_multi = 0;
  int            rsp_wait = 0, rsp_addr = 0;
  logic [DW-1:0] rsp_data = '0;
  int            busy_pct = 0, gnt_pct = 100, lat_min = 0, lat_max = 0;
  int            single_pct = 0, multi_pct = 0, spur_pct = 0;
  bit            busy_force = 0, clr_with_rsp = 0, clr_now = 0, frc_on = 0;
  bit            frc_single [NW];
  bit            frc_multi [NW];
  logic [DW-1:0] frc_data [NW];
  bit            last_req = 0;
  int            rd_cyc[$], rd_addr[$], wr_cyc[$], sd_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CntMax) ? CntMax : v;
  endfunction

  task automatic advance();
    if (exp_addr == NW - 1) begin
      exp_addr = 0;
      exp_sweeps++;
    end else begin
      exp_addr++;
    end
  endtask

  // One clock: sample registered outputs, drive inputs, then act as memory.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (sweep_done) begin
      seen_sweeps++;
      sd_cyc.push_back(cyc);
    end
    if (chk_cnt) begin
      chk("corr_cnt", 64'(corr_cnt), 64'(exp_corr));
      chk("uncorr_cnt", 64'(uncorr_cnt), 64'(exp_uncorr));
      chk("uncorr_addr", 64'(uncorr_addr), 64'(exp_uaddr));
      chk_cnt = 0;
    end
    bus_busy   = busy_force || ($urandom_range(99) < busy_pct);
    mem_rvalid = 1'b0;
    err_single = 1'b0;
    err_multi  = 1'b0;
    mem_rdata  = {$urandom, $urandom};
    clr_cnt    = clr_now;
    clr_now    = 0;
    if (rsp_pend) begin
      if (rsp_wait == 0) begin
        mem_rvalid = 1'b1;
        err_single = rsp_single;
        err_multi  = rsp_multi;
        mem_rdata  = rsp_data;
        rsp_pend   = 0;
        if (clr_with_rsp) clr_cnt = 1'b1;
        if (!rsp_stale) begin
          if (rsp_multi) begin
            exp_uncorr = sat(exp_uncorr + 1);
            exp_uaddr  = rsp_addr;
            advance();
          end else if (rsp_single) begin
            exp_corr    = sat(exp_corr + 1);
            exp_wdata   = rsp_data;
            exp_wr_pend = 1;
          end else begin
            advance();
          end
          chk_cnt = 1;
        end
        rsp_stale = 0;
      end else begin
        rsp_wait--;
      end
    end else if ($urandom_range(99) < spur_pct) begin
      mem_rvalid = 1'b1;
      err_single = 1'($urandom_range(1));
      err_multi  = 1'($urandom_range(1));
    end
    if (clr_cnt) begin
      exp_corr   = 0;
      exp_uncorr = 0;
      chk_cnt    = 1;
    end
    #1;
    last_req = mem_req;
    if (bus_busy) chk("req_masked", 64'(mem_req), 64'd0);
    if (mem_req) mem_gnt = ($urandom_range(99) < gnt_pct);
    else         mem_gnt = ($urandom_range(99) < spur_pct);
    if (mem_req && mem_gnt) begin
      if (!mem_we) begin
        chk("rd_addr", 64'(mem_addr), 64'(exp_addr));
        chk("rd_while_wr_due", 64'(exp_wr_pend), 64'd0);
        rd_cyc.push_back(cyc);
        rd_addr.push_back(int'(mem_addr));
        rsp_pend = 1;
        rsp_addr = int'(mem_addr);
        rsp_wait = $urandom_range(lat_max, lat_min);
        rsp_data = {$urandom, $urandom};
        if (frc_on) begin
          rsp_single = frc_single[mem_addr];
          rsp_multi  = frc_multi[mem_addr];
          if (rsp_single) rsp_data = frc_data[mem_addr];
        end else begin
          rsp_single = ($urandom_range(99) < single_pct);
          rsp_multi  = ($urandom_range(99) < multi_pct);
        end
      end else begin
        chk("wr_due", 64'(exp_wr_pend), 64'd1);
        chk("wr_addr", 64'(mem_addr), 64'(exp_addr));
        chk("wr_data", mem_wdata, exp_wdata);
        exp_wr_pend = 0;
        wr_cyc.push_back(cyc);
        advance();
      end
    end
  endtask

  task automatic run_reads(input int n, input int budget, input string tag);
    int target = rd_cyc.size() + n;
    int k = 0;
    while (rd_cyc.size() < target && k < budget) begin
      cycle();
      k++;
    end
    chk({tag, "_timeout"}, 64'(rd_cyc.size() >= target), 64'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < int'(NW); i++) begin
      frc_single[i] = 0;
      frc_multi[i]  = 0;
      frc_data[i]   = '0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_corr", 64'(corr_cnt), 64'd0);
    chk("rst_uncorr", 64'(uncorr_cnt), 64'd0);
    chk("rst_uaddr", 64'(uncorr_addr), 64'd0);
    chk("rst_sweep", 64'(sweep_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // Zero-wait full sweep: single error at 2, multi+single at 5.
    frc_on        = 1;
    frc_single[2] = 1;
    frc_data[2]   = 64'hDEAD;
    frc_single[5] = 1;
    frc_multi[5]  = 1;
    enable        = 1'b1;
    run_reads(9, 100, "sweep");
    frc_on = 0;
    if (rd_cyc.size() >= 9) begin
      for (int i = 0; i < 9; i++) chk("sweep_order", 64'(rd_addr[i]), 64'(i % NW));
      for (int i = 0; i < 8; i++)
        chk("word_cycles", 64'(rd_cyc[i+1] - rd_cyc[i]), (i == 2) ? 64'd5 : 64'd4);
      chk("wr_count", 64'(wr_cyc.size()), 64'd1);
      if (wr_cyc.size() > 0) chk("wr_cycle", 64'(wr_cyc[0]), 64'(rd_cyc[2] + 2));
      chk("sweep_pulses", 64'(sd_cyc.size()), 64'd1);
      if (sd_cyc.size() > 0) chk("sweep_cycle", 64'(sd_cyc[0]), 64'(rd_cyc[7] + 3));
    end
    chk("corr_after_sweep", 64'(corr_cnt), 64'd1);
    chk("uncorr_after_sweep", 64'(uncorr_cnt), 64'd1);
    chk("uaddr_after_sweep", 64'(uncorr_addr), 64'd5);

    // Functional traffic blocks the READ of word 1 for 10+ cycles.
    busy_force = 1;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (i >= 4) begin
        chk("busy_addr", 64'(mem_addr), 64'd1);
        chk("busy_we", 64'(mem_we), 64'd0);
      end
    end
    busy_force = 0;
    cycle();
    chk("req_after_busy", 64'(last_req), 64'd1);
    chk("rd_after_busy", 64'(rd_cyc[rd_cyc.size()-1]), 64'(cyc));

    // enable drops while the read of word 2 waits for its response.
    lat_min = 2;
    lat_max = 2;
    run_reads(1, 20, "pre_drop");
    cycle();
    enable = 1'b0;
    n = rd_cyc.size();
    repeat (6) cycle();
    chk("drop_idle", 64'(busy), 64'd0);
    chk("drop_no_req", 64'(last_req), 64'd0);
    chk("drop_no_read", 64'(rd_cyc.size()), 64'(n));
    lat_min = 0;
    lat_max = 0;
    enable  = 1'b1;
    run_reads(1, 20, "resume");
    chk("resume_addr", 64'(rd_addr[rd_addr.size()-1]), 64'd3);

    // interval 3 stretches WAIT to 4 cycles, giving 7 cycles per clean word.
    interval = 4'd3;
    run_reads(2, 40, "interval");
    chk("interval_cycles", 64'(rd_cyc[rd_cyc.size()-1] - rd_cyc[rd_cyc.size()-2]), 64'd7);
    interval = '0;

    // Saturation, then clear colliding with an increment.
    clr_now    = 1;
    single_pct = 100;
    run_reads(CntMax + 2, 400, "sat");
    cycle();
    cycle();
    chk("corr_sat", 64'(corr_cnt), 64'(CntMax));
    clr_with_rsp = 1;
    run_reads(1, 20, "clr_inc");
    for (int i = 0; i < 10 && rsp_pend; i++) cycle();
    cycle();
    clr_with_rsp = 0;
    chk("clr_beats_inc", 64'(corr_cnt), 64'd0);

    // Randomized traffic, errors, stalls, enable toggling and spurious handshakes.
    single_pct = 15;
    multi_pct  = 8;
    busy_pct   = 30;
    gnt_pct    = 60;
    lat_max    = 3;
    spur_pct   = 10;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) enable = ~enable;
      if ($urandom_range(99) == 0) interval = IW'($urandom_range(3));
      if ($urandom_range(199) == 0) clr_now = 1;
      cycle();
    end
    spur_pct = 0;
    busy_pct = 0;
    gnt_pct  = 100;
    enable   = 1'b0;
    repeat (40) cycle();
    chk("drain_idle", 64'(busy), 64'd0);
    chk("drain_rsp", 64'(rsp_pend), 64'd0);
    chk("drain_wr", 64'(exp_wr_pend), 64'd0);
    chk("drain_sweeps", 64'(seen_sweeps), 64'(exp_sweeps));
    chk("drain_addr", 64'(mem_addr), 64'(exp_addr));
    chk("drain_corr", 64'(corr_cnt), 64'(exp_corr));
    chk("drain_uncorr", 64'(uncorr_cnt), 64'(exp_uncorr));

    // Reset while a read is in flight; the late response must be ignored.
    single_pct = 100;
    multi_pct  = 0;
    lat_min    = 1;
    lat_max    = 1;
    enable     = 1'b1;
    run_reads(1, 40, "pre_rst");
    rst       = 1'b1;
    enable    = 1'b0;
    rsp_stale = 1;
    cycle();
    chk("rst_flight_req", 64'(last_req), 64'd0);
    chk("rst_flight_busy", 64'(busy), 64'd0);
    exp_addr    = 0;
    exp_corr    = 0;
    exp_uncorr  = 0;
    exp_uaddr   = 0;
    exp_wr_pend = 0;
    chk_cnt     = 0;
    rst         = 1'b0;
    cycle();
    cycle();
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_corr", 64'(corr_cnt), 64'd0);
    chk("post_rst_uncorr", 64'(uncorr_cnt), 64'd0);
    chk("post_rst_addr", 64'(mem_addr), 64'd0);
    chk("post_rst_wdata", mem_wdata, 64'd0);
    chk("post_rst_req", 64'(last_req), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
